m_cp0: RTL
==========

# m_cp0

Coprocessor 0 for the five-stage MIPS pipeline, placed in the M stage directly beside the M-stage controller. It consumes the controller's `mtc0_M`, `eret_M` and `rd_M` decodes plus the M-stage PC and the exception code accumulated down the pipe. It holds SR, Cause, EPC and PRId, and raises a single-cycle-evaluated exception/interrupt request that flushes the pipe and redirects fetch to the handler.

## Interface
- `PRID_VAL`, 32'h2023_0707: constant returned on reads of PRId (reg 15).
- `HW_INT_W`, 6: number of hardware interrupt lines (fixed at 6; maps to IM/IP bits 15:10).
- `clk` input 1: system clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all CP0 state immediately.
- `en` input 1: write enable, driven by `mtc0_M`.
- `addr` input 5: CP0 register number, driven by `rd_M`.
- `din` input 32: mtc0 write data (forwarded rt value in M).
- `pc_M` input 32: PC of the instruction currently in M.
- `bd_M` input 1: instruction in M sits in a branch delay slot.
- `exc_code_M` input 5: pending exception code from earlier stages; 0 = none.
- `eret_M` input 1: eret instruction in M.
- `hw_int` input 6: external interrupt lines (timer0, timer1, external, …), level-sensitive.
- `dout` output 32: combinational read of register `addr` (mfc0 data).
- `req` output 1: exception/interrupt accepted this cycle; flush all stages, fetch from handler entry.
- `epc_out` output 32: current EPC, used by eret to redirect fetch.

## Operation
- Registers: SR = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}; Cause = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}; EPC 32 bits, word-aligned; PRId read-only = `PRID_VAL`. Unimplemented fields read 0.
- Interrupt request `int_req` = IE & !EXL & |(IM & hw_int).
- Exception request `exc_req` = (exc_code_M != 0) & !EXL.
- `req` = int_req | exc_req (combinational). Interrupt has priority over exception.
- On `req` at the clock edge: EXL <= 1; Cause.BD <= bd_M; ExcCode <= int_req ? 0 : exc_code_M; EPC <= (bd_M ? pc_M - 4 : pc_M) with bits [1:0] forced 0.
- Cause.IP <= hw_int every cycle, regardless of other events.
- `eret_M` & !req: EXL <= 0 at the edge. EPC is unchanged.
- `en` & !req: write `din` to SR (12), or EPC (14, bits [1:0] forced 0); writes to Cause, PRId or any other address are ignored. SR writes keep only IM, EXL and IE.
- `req` together with `en` or `eret_M`: the request wins, and the write or eret is discarded; the instruction is re-executed after return.
- `dout`: reg 12 → SR, 13 → Cause, 14 → EPC, 15 → PRId, others → 0. Reads show the pre-edge value, with no write-through.
- `epc_out` = EPC register, with no bypass of a same-cycle mtc0 to EPC. The hazard unit stalls eret in D until the mtc0 retires.

## Timing
- Reset (async): SR, Cause, EPC = 0; `req` = 0; `dout` = 0 for addr 12–14; `epc_out` = 0.
- `req`, `dout` and `epc_out` are combinational from the current state and inputs, with zero latency. State updates take effect at the next rising edge.
- One request per cycle. After an accepted request, EXL = 1 masks all further requests until eret or an mtc0 clears EXL.
- Reset asserted mid-request: state clears at once, and `req` drops within the same cycle.
- `hw_int` changing while EXL = 1: IP tracks the lines, but no request is raised.

## Test plan
- Reset with hw_int = 6'h3F: then SR = 0, Cause.IP = 6'h3F one edge later, `req` = 0.
- mtc0 addr 12, din 32'h0000_FC01; then hw_int = 6'b000001 with pc_M = 32'h3008 → `req` = 1 same cycle. After the edge: EPC = 32'h3008, ExcCode = 0, EXL = 1; `req` then 0.
- EXL = 0, IE = 0, exc_code_M = 5'd10 (RI), bd_M = 1, pc_M = 32'h3010 → `req` = 1. After the edge: EPC = 32'h300C, BD = 1, ExcCode = 10.
- Simultaneous interrupt (IM/IE set, hw_int[2] = 1) and exc_code_M = 5'd4 → ExcCode = 0 (interrupt wins). With en = 1 and addr 14 in the same cycle, EPC = pc_M, not din.
- EXL = 1, eret_M = 1 → EXL = 0 after the edge, `epc_out` unchanged. A pending enabled interrupt then raises `req` in the next cycle.
- mtc0 addr 14, din 32'h0000_3017 → EPC reads 32'h0000_3014. mtc0 addr 13 or 15 leaves Cause and PRId unchanged; mfc0 addr 15 → 32'h2023_0707.

Source files
------------

// File: rtl/m_cp0.sv
// m_cp0: MIPS coprocessor 0 holding SR, Cause, EPC and PRId and raising the M-stage exception/interrupt request
module m_cp0 #(
  parameter logic [31:0] PRID_VAL = 32'h2023_0707,
  parameter int          HW_INT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [4:0]          addr,
  input  logic [31:0]         din,
  input  logic [31:0]         pc_M,
  input  logic                bd_M,
  input  logic [4:0]          exc_code_M,
  input  logic                eret_M,
  input  logic [HW_INT_W-1:0] hw_int,
  output logic [31:0]         dout,
  output logic                req,
  output logic [31:0]         epc_out
);
  logic [HW_INT_W-1:0] im_q, im_d, ip_q, ip_d;
  logic                exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  logic [4:0]          exc_q, exc_d;
  logic [29:0]         epc_q, epc_d;
  logic                int_req, exc_req, wr_sr, wr_epc;
  logic [29:0]         epc_src;
  logic [31:0]         sr, cause, epc;
  logic                unused;
  assign unused = ^pc_M[1:0];
  assign int_req = ie_q & ~exl_q & |(im_q & hw_int);
  assign exc_req = (exc_code_M != 5'd0) & ~exl_q;
  // gated by reset so a request in flight drops in the same cycle reset rises
  assign req     = ~reset & (int_req | exc_req);
  assign wr_sr   = en & ~req & (addr == 5'd12);
  assign wr_epc  = en & ~req & (addr == 5'd14);
  assign epc_src = pc_M[31:2] - {29'd0, bd_M};
  assign sr      = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause   = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
  assign epc     = {epc_q, 2'b00};
  assign epc_out = epc;
  always_comb begin
    ip_d  = hw_int;
    im_d  = wr_sr ? din[15:10] : im_q;
    ie_d  = wr_sr ? din[0] : ie_q;
    exl_d = req ? 1'b1 : wr_sr ? din[1] : eret_M ? 1'b0 : exl_q;
    bd_d  = req ? bd_M : bd_q;
    exc_d = req ? (int_req ? 5'd0 : exc_code_M) : exc_q;
    epc_d = req ? epc_src : wr_epc ? din[31:2] : epc_q;
    dout  = addr == 5'd12 ? sr :
            addr == 5'd13 ? cause :
            addr == 5'd14 ? epc :
            addr == 5'd15 ? PRID_VAL : 32'd0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q  <= '0;
      ip_q  <= '0;
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
      bd_q  <= 1'b0;
      exc_q <= 5'd0;
      epc_q <= 30'd0;
    end else begin
      im_q  <= im_d;
      ip_q  <= ip_d;
      ie_q  <= ie_d;
      exl_q <= exl_d;
      bd_q  <= bd_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end
endmodule
